// File: rtl/bin2bcd_if.sv
// ============================================================================
// Module   : bin2bcd_if
// Purpose  : start/busy/done handshake and result bus of the serial converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin2bcd_if #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd, neg, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd, neg, overflow
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Multi-cycle double-dabble binary to packed-BCD converter with
//            optional two's-complement input and saturating overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  bin2bcd_if.slave   bus
);

  localparam int c_sw   = 4*DIGITS + 4;
  localparam int c_cmpw = (WIDTH > 34) ? WIDTH : 34;
  localparam int c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [c_cmpw-1:0] pow10(input int n);
    logic [c_cmpw-1:0] p;
    p = c_cmpw'(1);
    for (int i = 0; i < n; i++) begin
      p = p * c_cmpw'(10);
    end
    return p;
  endfunction

  localparam logic [c_cmpw-1:0] c_limit = pow10(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_mag;
  logic                  r_sign;
  logic                  r_ovf;
  logic [c_sw-1:0]       r_scratch;
  logic [c_cw-1:0]       r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_neg;
  logic                  r_overflow;

  logic                  w_neg;
  logic [WIDTH-1:0]      w_mag;
  logic                  w_ovf;
  logic [3:0]            w_guard;
  logic [3:0]            w_guard_adj;
  logic [c_sw-2:0]       w_adj;
  logic [c_sw-1:0]       w_next;

  // Negation in WIDTH bits maps the most negative input onto 2^(WIDTH-1) exactly.
  assign w_neg = (SIGNED != 0) && bus.bin_in[WIDTH-1];
  assign w_mag = w_neg ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
  assign w_ovf = (c_cmpw'(w_mag) >= c_limit);

  // Only the guard digit's low three bits survive the shift, so only those are kept.
  assign w_guard     = r_scratch[c_sw-1 -: 4];
  assign w_guard_adj = (w_guard >= 4'd5) ? (w_guard + 4'd3) : w_guard;

  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ?
                        (r_scratch[4*d +: 4] + 4'd3) : r_scratch[4*d +: 4];
    end
    w_adj[c_sw-2 -: 3] = w_guard_adj[2:0];
  end

  assign w_next = {w_adj, r_mag[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mag      <= '0;
      r_sign     <= 1'b0;
      r_ovf      <= 1'b0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_mag     <= w_mag;
            r_sign    <= w_neg;
            r_ovf     <= w_ovf;
            r_scratch <= '0;
            r_cnt     <= c_cw'(WIDTH - 1);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_next;
          r_mag     <= r_mag << 1;
          if (r_cnt == '0) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_bcd      <= r_ovf ? {DIGITS{4'h9}} : w_next[4*DIGITS-1:0];
            r_neg      <= r_sign;
            r_overflow <= r_ovf;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.neg      = r_neg;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Directed self-checking bench for bin2bcd_seq (12b signed and
//            10b unsigned instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  bin2bcd_if #(.WIDTH(12), .DIGITS(4)) a_if ();
  bin2bcd_if #(.WIDTH(10), .DIGITS(3)) b_if ();

  bin2bcd_seq #(.WIDTH(12), .DIGITS(4), .SIGNED(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3), .SIGNED(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and waits (bounded) for done; lat counts edges incl. the accepting one.
  task automatic run_a(input logic [11:0] v, output logic [15:0] bcd, output logic n,
                       output logic o, output int lat, output int busy_cyc);
    a_if.bin_in = v;
    a_if.start  = 1'b1;
    tick();
    a_if.start  = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!a_if.done && lat < 40) begin
      if (a_if.busy) busy_cyc++;
      tick();
      lat++;
    end
    bcd = a_if.bcd;
    n   = a_if.neg;
    o   = a_if.overflow;
  endtask

  task automatic run_b(input logic [9:0] v, output logic [11:0] bcd, output logic n,
                       output logic o, output int lat);
    b_if.bin_in = v;
    b_if.start  = 1'b1;
    tick();
    b_if.start  = 1'b0;
    lat = 1;
    while (!b_if.done && lat < 40) begin
      tick();
      lat++;
    end
    bcd = b_if.bcd;
    n   = b_if.neg;
    o   = b_if.overflow;
  endtask

  task automatic test_reset();
    logic [19:0] obs_a;
    logic [15:0] obs_b;
    rst = 1'b1;
    a_if.start = 1'b0; a_if.bin_in = '0;
    b_if.start = 1'b0; b_if.bin_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    obs_a = {a_if.busy, a_if.done, a_if.bcd, a_if.neg, a_if.overflow};
    n_checks++;
    if (obs_a !== 20'h0) $display("FAIL reset_a: got %h want 00000", obs_a);
    else n_pass++;
    obs_b = {b_if.busy, b_if.done, b_if.bcd, b_if.neg, b_if.overflow};
    n_checks++;
    if (obs_b !== 16'h0) $display("FAIL reset_b: got %h want 0000", obs_b);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [11:0] vin [4] = '{12'h7FF, 12'h800, 12'hFFF, 12'h000};
    logic [15:0] vbcd[4] = '{16'h2047, 16'h2048, 16'h0001, 16'h0000};
    logic        vneg[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] bcd;
    logic n, o;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_a(vin[i], bcd, n, o, lat, bc);
      n_checks++;
      if ({bcd, n, o} !== {vbcd[i], vneg[i], 1'b0})
        $display("FAIL signed_%0d: got bcd=%h neg=%b ovf=%b want bcd=%h neg=%b ovf=0",
                 i, bcd, n, o, vbcd[i], vneg[i]);
      else n_pass++;
      n_checks++;
      if (lat !== 13 || bc !== 12)
        $display("FAIL timing_%0d: got latency=%0d busy=%0d want 13/12", i, lat, bc);
      else n_pass++;
      tick();
      n_checks++;
      if (a_if.done !== 1'b0) $display("FAIL done_width_%0d: got %b want 0", i, a_if.done);
      else n_pass++;
    end
  endtask

  task automatic test_unsigned();
    logic [9:0]  vin [4] = '{10'd999, 10'd1000, 10'd1023, 10'd0};
    logic [11:0] vbcd[4] = '{12'h999, 12'h999, 12'h999, 12'h000};
    logic        vovf[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] bcd;
    logic n, o;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_b(vin[i], bcd, n, o, lat);
      n_checks++;
      if ({bcd, n, o, lat} !== {vbcd[i], 1'b0, vovf[i], 32'd11})
        $display("FAIL unsigned_%0d: got bcd=%h neg=%b ovf=%b lat=%0d want bcd=%h neg=0 ovf=%b lat=11",
                 i, bcd, n, o, lat, vbcd[i], vovf[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [15:0] got;
    a_if.bin_in = 12'd25;
    a_if.start  = 1'b1;
    tick();
    a_if.start  = 1'b0;
    repeat (3) tick();
    a_if.bin_in = 12'd100;
    a_if.start  = 1'b1;
    tick();
    a_if.start  = 1'b0;
    dones = 0;
    got   = '0;
    for (int c = 0; c < 30; c++) begin
      if (a_if.done) begin
        dones++;
        got = a_if.bcd;
      end
      tick();
    end
    n_checks++;
    if (dones !== 1) $display("FAIL ignore_count: got %0d done pulses want 1", dones);
    else n_pass++;
    n_checks++;
    if (got !== 16'h0025) $display("FAIL ignore_value: got %h want 0025", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] vin [4] = '{12'd123, 12'hF38, 12'd7, 12'd0};
    logic [15:0] vbcd[3] = '{16'h0123, 16'h0200, 16'h0007};
    logic        vneg[3] = '{1'b0, 1'b1, 1'b0};
    int cyc;
    a_if.bin_in = vin[0];
    a_if.start  = 1'b1;
    tick();
    a_if.bin_in = vin[1];
    cyc = 1;
    for (int k = 0; k < 3; k++) begin
      while (!a_if.done && cyc < 40) begin
        tick();
        cyc++;
      end
      n_checks++;
      if ({a_if.done, a_if.bcd, a_if.neg} !== {1'b1, vbcd[k], vneg[k]})
        $display("FAIL b2b_value_%0d: got done=%b bcd=%h neg=%b want done=1 bcd=%h neg=%b",
                 k, a_if.done, a_if.bcd, a_if.neg, vbcd[k], vneg[k]);
      else n_pass++;
      n_checks++;
      if (cyc !== 13) $display("FAIL b2b_period_%0d: got %0d want 13", k, cyc);
      else n_pass++;
      if (k == 2) a_if.start = 1'b0;
      tick();
      cyc = 1;
      a_if.bin_in = vin[k+1 < 3 ? k+2 : 3];
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] bcd;
    logic n, o;
    int lat, bc, dones;
    logic [18:0] obs;
    run_a(12'hFFF, bcd, n, o, lat, bc);
    tick();
    a_if.bin_in = 12'h123;
    a_if.start  = 1'b1;
    tick();
    a_if.start  = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    obs = {a_if.busy, a_if.done, a_if.bcd, a_if.neg};
    n_checks++;
    if (obs !== 19'h0) $display("FAIL async_reset: got %h want 00000", obs);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (a_if.done || a_if.busy) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL post_reset_quiet: got %0d active cycles want 0", dones);
    else n_pass++;
    run_a(12'h0FA, bcd, n, o, lat, bc);
    n_checks++;
    if ({bcd, n, o, lat} !== {16'h0250, 1'b0, 1'b0, 32'd13})
      $display("FAIL after_reset: got bcd=%h neg=%b ovf=%b lat=%0d want 0250/0/0/13", bcd, n, o, lat);
    else n_pass++;
    tick();
  endtask

  task automatic test_sweep();
    logic [15:0] bcd, exp_bcd;
    logic n, o, exp_n;
    int lat, bc, m;
    for (int x = 0; x < 4096; x++) begin
      repeat ($urandom_range(0, 2)) tick();
      run_a(12'(x), bcd, n, o, lat, bc);
      exp_n   = (x >= 2048);
      m       = exp_n ? 4096 - x : x;
      exp_bcd = {4'((m / 1000) % 10), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
      n_checks++;
      if ({bcd, n, o, lat} !== {exp_bcd, exp_n, 1'b0, 32'd13})
        $display("FAIL sweep_%0d: got bcd=%h neg=%b ovf=%b lat=%0d want bcd=%h neg=%b ovf=0 lat=13",
                 x, bcd, n, o, lat, exp_bcd, exp_n);
      else n_pass++;
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_signed();
    test_unsigned();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
